// File: rtl/data_memory_if.sv
// Load/store port bundle for data_memory; the master is the datapath, the slave is the RAM.
// write_strobe exists only when DATAMEM_BYTE_STROBE_EN is defined.
interface data_memory_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
`ifdef DATAMEM_BYTE_STROBE_EN
    logic [3:0]  write_strobe;
`endif
    logic [31:0] read_data;
    logic        addr_error;

    modport master (
        output address,
        output write_data,
        output write_enable,
        output read_enable,
`ifdef DATAMEM_BYTE_STROBE_EN
        output write_strobe,
`endif
        input  read_data,
        input  addr_error
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        input  read_enable,
`ifdef DATAMEM_BYTE_STROBE_EN
        input  write_strobe,
`endif
        output read_data,
        output addr_error
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous writes, combinational reads, out-of-range accesses flagged.
// Optional per-byte write lanes when DATAMEM_BYTE_STROBE_EN is defined.
module data_memory #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    data_memory_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]       idx;
    logic [AW-1:0]     widx;
    logic              in_range;
    logic              wr_en;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign idx  = bus.address[31:2];
    assign widx = idx[AW-1:0];

    // Full-width compare so high address bits never alias onto a valid word.
    assign in_range = ({34'd0, idx} < 64'(DEPTH));
    assign wr_en    = rst_n & bus.write_enable & in_range;

    always_comb begin
`ifdef DATAMEM_BYTE_STROBE_EN
        wdata_d = mem_q[widx];
        for (int unsigned k = 0; k < 4; k++) begin
            if (bus.write_strobe[k]) begin
                wdata_d[8*k +: 8] = bus.write_data[8*k +: 8];
            end
        end
`else
        wdata_d = bus.write_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[widx] <= wdata_d;
        end
    end

    assign bus.read_data  = (rst_n & bus.read_enable & in_range) ? mem_q[widx] : '0;
    assign bus.addr_error = rst_n & (bus.read_enable | bus.write_enable) & ~in_range;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table plus hand sequences, checked through a queue.
module tb_data_memory;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   step_id;
    vec_t vecs[$];
    exp_t sb[$];

    data_memory_if bus ();

    data_memory #(.DEPTH(256), .DATA_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, check the pre-edge outputs, then let the edge happen.
    task automatic step(input vec_t v);
        exp_t e;
        rst_n            = v.rst_n;
        bus.write_enable = v.we;
        bus.read_enable  = v.re;
        bus.address      = v.addr;
        bus.write_data   = v.wdata;
`ifdef DATAMEM_BYTE_STROBE_EN
        bus.write_strobe = v.strb;
`endif
        sb.push_back('{v.exp_rd, v.exp_err, step_id});
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty step %0d", step_id);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.read_data !== e.rd) begin
                errors++;
                $display("FAIL read_data step %0d: got %h expected %h", e.id, bus.read_data, e.rd);
            end
            checks++;
            if (bus.addr_error !== e.err) begin
                errors++;
                $display("FAIL addr_error step %0d: got %b expected %b", e.id, bus.addr_error, e.err);
            end
        end
        step_id++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic re,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] s, input logic [31:0] rd, input logic err);
        vec_t v;
        v = '{r, we, re, a, wd, s, rd, err};
        return v;
    endfunction

    initial begin
        errors  = 0;
        checks  = 0;
        step_id = 0;
        rst_n            = 1'b0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
`ifdef DATAMEM_BYTE_STROBE_EN
        bus.write_strobe = 4'hF;
`endif

        //                rst  we  re   addr          wdata         strb   exp_rd        err
        vecs.push_back(mk(0,   0,  1,   32'h0000_0004, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0004, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   1,  0,   32'h0000_0004, 32'hDEADBEEF, 4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   1,  0,   32'h0000_0008, 32'hCAFEBABE, 4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0004, 32'h0,        4'hF,  32'hDEADBEEF, 0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0008, 32'h0,        4'hF,  32'hCAFEBABE, 0));
        vecs.push_back(mk(1,   0,  0,   32'h0000_0008, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0006, 32'h0,        4'hF,  32'hDEADBEEF, 0));
        vecs.push_back(mk(1,   1,  1,   32'h0000_0004, 32'h12345678, 4'hF,  32'hDEADBEEF, 0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0004, 32'h0,        4'hF,  32'h12345678, 0));
        vecs.push_back(mk(1,   1,  0,   32'h0000_0400, 32'hFFFFFFFF, 4'hF,  32'h0,        1));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0400, 32'h0,        4'hF,  32'h0,        1));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0000, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   1,  1,   32'h0000_03FC, 32'h55555555, 4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_03FC, 32'h0,        4'hF,  32'h55555555, 0));
        vecs.push_back(mk(1,   0,  1,   32'hFFFF_FFFC, 32'h0,        4'hF,  32'h0,        1));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0002, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   1,  0,   32'h0000_000C, 32'h77777777, 4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_000C, 32'h0,        4'hF,  32'h77777777, 0));
        vecs.push_back(mk(0,   0,  1,   32'h0000_0400, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(0,   1,  1,   32'h0000_000C, 32'hAAAAAAAA, 4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_000C, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_0004, 32'h0,        4'hF,  32'h0,        0));
        vecs.push_back(mk(1,   0,  1,   32'h0000_03FC, 32'h0,        4'hF,  32'h0,        0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Enables held high: one write per edge, each read showing the previous edge's value.
        step(mk(1, 1, 1, 32'h0000_0020, 32'h0000_00A1, 4'hF, 32'h0,         0));
        step(mk(1, 1, 1, 32'h0000_0020, 32'h0000_00B2, 4'hF, 32'h0000_00A1, 0));
        step(mk(1, 1, 1, 32'h0000_0020, 32'h0000_00C3, 4'hF, 32'h0000_00B2, 0));
        step(mk(1, 0, 1, 32'h0000_0020, 32'h0,         4'hF, 32'h0000_00C3, 0));

`ifdef DATAMEM_BYTE_STROBE_EN
        step(mk(1, 1, 0, 32'h0000_0010, 32'h11223344, 4'hF, 32'h0,        0));
        step(mk(1, 1, 1, 32'h0000_0010, 32'hAABBCCDD, 4'h5, 32'h11223344, 0));
        step(mk(1, 0, 1, 32'h0000_0010, 32'h0,        4'hF, 32'h11BB33DD, 0));
        step(mk(1, 1, 0, 32'h0000_0010, 32'hFFFFFFFF, 4'h0, 32'h0,        0));
        step(mk(1, 0, 1, 32'h0000_0010, 32'h0,        4'hF, 32'h11BB33DD, 0));
        step(mk(1, 1, 0, 32'h0000_0010, 32'h99999999, 4'hA, 32'h0,        0));
        step(mk(1, 0, 1, 32'h0000_0010, 32'h0,        4'hF, 32'h99BB99DD, 0));
`else
        step(mk(1, 1, 0, 32'h0000_0010, 32'h11223344, 4'hF, 32'h0,        0));
        step(mk(1, 1, 1, 32'h0000_0010, 32'hAABBCCDD, 4'h5, 32'h11223344, 0));
        step(mk(1, 0, 1, 32'h0000_0010, 32'h0,        4'hF, 32'hAABBCCDD, 0));
`endif

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Word-organised data RAM for the single-cycle RISC-V datapath, serving the load/store stage.
- Writes are synchronous on the rising clock edge.
- Reads are combinational, so load data is available within the same cycle.
- Byte addresses come from the ALU; out-of-range accesses are flagged and made harmless.

Parameters:
DEPTH, 256, number of 32-bit words (any value >= 1; need not be a power of two)
DATA_W, 32, data word width; fixed at 32 for this core, exposed for documentation only

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  synchronous active-low reset
address  input  32  byte address; word index = address[31:2]
write_data  input  32  store data
write_enable  input  1  store request, sampled at rising edge
read_enable  input  1  load request, combinational
read_data  output  32  load data
addr_error  output  1  combinational flag: enabled access with word index >= DEPTH

Behaviour:
- Storage: DEPTH x 32-bit array, indexed by idx = address[31:2]. address[1:0] is ignored (forced word alignment).
- in_range = (idx < DEPTH), computed over the full 30-bit idx with no truncation or wrap.
- Reset, synchronous: at a rising edge with rst_n=0, every word is cleared to 0 and any write that cycle is discarded.
- Output during reset: read_data=0 and addr_error=0 while rst_n=0, combinationally.
- Write: at a rising edge with rst_n=1, write_enable=1 and in_range, mem[idx] <= write_data. Out-of-range writes change nothing.
- Read: read_data = mem[idx] when rst_n=1, read_enable=1 and in_range; otherwise 0. Purely combinational, zero-cycle latency.
- Read-during-write to the same word: before the edge, read_data shows the old contents. After the edge it shows the new value in the same settling window; there is no bypass.
- Simultaneous read and write to different words are independent.
- addr_error = rst_n & (read_enable | write_enable) & ~in_range.
- Word contents before the first reset are X (simulation) or don't-care.
- Enables held high across consecutive cycles perform one write per edge.

Optional Feature:
Macro DATAMEM_BYTE_STROBE_EN.
- Defined: adds port write_strobe, input, 4 bits.
  - On a qualifying write, byte lane k (bits 8k+7:8k) of mem[idx] is updated only if write_strobe[k]=1.
  - write_strobe=4'b0000 writes nothing.
  - Reads are unaffected (always full word).
- Undefined: the port is absent and every qualifying write updates all 32 bits, equivalent to strobe 4'b1111.

Test Plan:
1. Reset then read: rst_n=0 for one edge, release, read_enable=1, address=0x4 -> read_data=0x00000000, addr_error=0.
2. Write/read back:
   - Write 0xDEADBEEF to 0x4 and 0xCAFEBABE to 0x8, one edge each.
   - Then read_enable=1 at 0x4 -> 0xDEADBEEF; at 0x8 -> 0xCAFEBABE.
   - read_enable=0 -> read_data=0.
3. Alignment and read-during-write:
   - Read at 0x6 after test 2 -> 0xDEADBEEF (low bits ignored).
   - Write 0x12345678 to 0x4 with read_enable=1 -> 0xDEADBEEF before the edge, 0x12345678 after.
4. Out of range, DEPTH=256:
   - Write 0xFFFFFFFF to 0x400 -> addr_error=1.
   - Read at 0x400 -> read_data=0, addr_error=1.
   - Read at 0x0 afterwards -> unchanged, no aliasing.
5. Reset mid-operation:
   - rst_n=0 with write_enable=1, 0xAAAAAAAA to 0xC at the edge -> write discarded.
   - After release, reads at 0xC and 0x4 both return 0.
6. With DATAMEM_BYTE_STROBE_EN:
   - mem[0x10]=0x11223344, then write 0xAABBCCDD with strobe 4'b0101 -> read 0x11BB33DD.
   - Strobe 4'b0000 -> unchanged.
